// File: rtl/cdb_pkg.sv
// Shared CDB definitions: default bus widths and the one-hot reservation-station
// tags used by the register file, the adder RS and the CDB arbiter.
package cdb_pkg;

  localparam int unsigned CDB_DATA_W = 32;
  localparam int unsigned CDB_TAG_W  = 6;

  // One-hot RS identifiers carried on CDB_source
  localparam logic [CDB_TAG_W-1:0] RS_NONE  = 6'b000000;
  localparam logic [CDB_TAG_W-1:0] RS_ADD1  = 6'b000001;
  localparam logic [CDB_TAG_W-1:0] RS_ADD2  = 6'b000010;
  localparam logic [CDB_TAG_W-1:0] RS_ADD3  = 6'b000100;
  localparam logic [CDB_TAG_W-1:0] RS_MUL1  = 6'b001000;
  localparam logic [CDB_TAG_W-1:0] RS_MUL2  = 6'b010000;
  localparam logic [CDB_TAG_W-1:0] RS_LOAD1 = 6'b100000;

endpackage

// File: rtl/cdb_arbiter_rr_priority_pick.sv
// Combinational rotating-priority picker.
// Ports:
//   i_req    - request vector, one bit per unit
//   i_ptr    - index where the circular search starts (must be < N)
//   o_gnt_c  - one-hot of the first requester at or after i_ptr
//   o_idx_c  - binary index of that requester
//   o_any_c  - high when any request is present
module rr_priority_pick #(
  parameter int unsigned N     = 3,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt_c,
  output logic [IDX_W-1:0] o_idx_c,
  output logic             o_any_c
);

  // Walk the ring from farthest to nearest so the nearest hit wins last
  always_comb begin : pick
    int pos;
    pos     = 0;
    o_gnt_c = '0;
    o_idx_c = '0;
    o_any_c = 1'b0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      pos = int'(i_ptr) + k;
      if (pos >= int'(N)) pos = pos - int'(N);
      if (i_req[pos]) begin
        o_gnt_c      = '0;
        o_gnt_c[pos] = 1'b1;
        o_idx_c      = IDX_W'(pos);
        o_any_c      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus. Units raise rts with their result
// and RS tag; the arbiter issues a one-cycle one-hot xmit grant and, on the next
// edge, broadcasts the granted unit's data/tag with a one-cycle CDB_write.
// Ports:
//   clock, reset  - rising-edge clock, synchronous active-high reset
//   unit_rts      - per-unit ready-to-send
//   unit_data     - per-unit result, unit i at [i*DATA_W +: DATA_W]
//   unit_source   - per-unit RS tag, unit i at [i*TAG_W +: TAG_W]
//   cdb_hold      - blocks new grants while high
//   unit_xmit     - one-hot grant pulse
//   CDB_data, CDB_source, CDB_write - registered bus beat
//   starve        - sticky per-unit starvation flag
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int unsigned NUM_UNITS = 3,
  parameter int unsigned DATA_W    = CDB_DATA_W,
  parameter int unsigned TAG_W     = CDB_TAG_W,
  parameter int unsigned MAX_WAIT  = 15
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_UNITS-1:0]        unit_rts,
  input  logic [NUM_UNITS*DATA_W-1:0] unit_data,
  input  logic [NUM_UNITS*TAG_W-1:0]  unit_source,
  input  logic                        cdb_hold,
  output logic [NUM_UNITS-1:0]        unit_xmit,
  output logic [DATA_W-1:0]           CDB_data,
  output logic [TAG_W-1:0]            CDB_source,
  output logic                        CDB_write,
  output logic [NUM_UNITS-1:0]        starve
);

  localparam int unsigned IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  logic [IDX_W-1:0]     r_ptr;
  logic [NUM_UNITS-1:0] r_xmit;
  logic [DATA_W-1:0]    r_data;
  logic [TAG_W-1:0]     r_source;
  logic                 r_write;
  logic [NUM_UNITS-1:0] r_starve;
  logic [CNT_W-1:0]     r_wait [NUM_UNITS];

  logic [NUM_UNITS-1:0] w_elig;
  logic [NUM_UNITS-1:0] w_pick_oh;
  logic [IDX_W-1:0]     w_pick_idx;
  logic                 w_pick_any;
  logic                 w_issue;
  logic [NUM_UNITS-1:0] w_gnt;
  logic [IDX_W-1:0]     w_ptr_nxt;
  logic [DATA_W-1:0]    w_sel_data;
  logic [TAG_W-1:0]     w_sel_source;
  logic [CNT_W-1:0]     w_wait_nxt [NUM_UNITS];
  logic [NUM_UNITS-1:0] w_starve_nxt;

  // A unit in its xmit cycle is masked so a lingering rts is never double-granted
  assign w_elig = unit_rts & ~r_xmit;

  rr_priority_pick #(
    .N     (NUM_UNITS),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req   (w_elig),
    .i_ptr   (r_ptr),
    .o_gnt_c (w_pick_oh),
    .o_idx_c (w_pick_idx),
    .o_any_c (w_pick_any)
  );

  assign w_issue   = ~cdb_hold & w_pick_any;
  assign w_gnt     = w_issue ? w_pick_oh : '0;
  assign w_ptr_nxt = (w_pick_idx == IDX_W'(NUM_UNITS - 1)) ? '0 : w_pick_idx + IDX_W'(1);

  // Select the payload of the unit currently holding xmit
  always_comb begin
    w_sel_data   = '0;
    w_sel_source = '0;
    for (int i = 0; i < int'(NUM_UNITS); i++) begin
      if (r_xmit[i]) begin
        w_sel_data   = unit_data[i*DATA_W +: DATA_W];
        w_sel_source = unit_source[i*TAG_W +: TAG_W];
      end
    end
  end

  // Wait counters: count pending-but-ungranted cycles, saturate at MAX_WAIT
  always_comb begin
    w_starve_nxt = r_starve;
    for (int i = 0; i < int'(NUM_UNITS); i++) begin
      w_wait_nxt[i] = r_wait[i];
      if (!unit_rts[i] || w_gnt[i] || r_xmit[i]) begin
        w_wait_nxt[i] = '0;
      end else if (r_wait[i] != CNT_W'(MAX_WAIT)) begin
        w_wait_nxt[i] = r_wait[i] + CNT_W'(1);
      end
      if (w_wait_nxt[i] == CNT_W'(MAX_WAIT)) w_starve_nxt[i] = 1'b1;
    end
  end

  // Grant stage, transfer stage and counters
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr    <= '0;
      r_xmit   <= '0;
      r_data   <= '0;
      r_source <= '0;
      r_write  <= 1'b0;
      r_starve <= '0;
      for (int i = 0; i < int'(NUM_UNITS); i++) r_wait[i] <= '0;
    end else begin
      r_xmit <= w_gnt;
      if (w_issue) r_ptr <= w_ptr_nxt;
      r_write <= |r_xmit;
      if (|r_xmit) begin
        r_data   <= w_sel_data;
        r_source <= w_sel_source;
      end
      r_starve <= w_starve_nxt;
      for (int i = 0; i < int'(NUM_UNITS); i++) r_wait[i] <= w_wait_nxt[i];
    end
  end

  assign unit_xmit  = r_xmit;
  assign CDB_data   = r_data;
  assign CDB_source = r_source;
  assign CDB_write  = r_write;
  assign starve     = r_starve;

  // Unit contract: payload must not change across the xmit cycle
  for (genvar gi = 0; gi < int'(NUM_UNITS); gi++) begin : g_contract
    a_payload_stable : assert property (@(posedge clock) disable iff (reset)
      r_xmit[gi] |->
        (unit_data[gi*DATA_W +: DATA_W] == $past(unit_data[gi*DATA_W +: DATA_W])) &&
        (unit_source[gi*TAG_W +: TAG_W] == $past(unit_source[gi*TAG_W +: TAG_W])));
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Round-robin arbiter for the common data bus (CDB) shared by all functional units (adder, multiplier, load unit, ...).
- Each unit raises a ready-to-send flag with its result and RS tag. The arbiter returns a one-cycle transmit grant, then drives the registered CDB data, source and write strobe consumed by the register file and the reservation stations.
- Replaces the single-unit rts/xmit toggle in the top level and scales to several execution units.

Parameters:
- NUM_UNITS, 3, number of requesting functional units (2..8).
- DATA_W, 32, CDB data width (signed result).
- TAG_W, 6, RS tag width (one-hot reservation-station identifier).
- MAX_WAIT, 15, wait cycles after which a pending request flags starvation.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- unit_rts  in  NUM_UNITS  per-unit ready-to-send.
- unit_data  in  NUM_UNITS*DATA_W  per-unit result, unit i at bits [i*DATA_W +: DATA_W].
- unit_source  in  NUM_UNITS*TAG_W  per-unit RS tag, unit i at bits [i*TAG_W +: TAG_W].
- cdb_hold  in  1  blocks new grants while high.
- unit_xmit  out  NUM_UNITS  one-hot grant, one-cycle pulse.
- CDB_data  out  DATA_W  broadcast result.
- CDB_source  out  TAG_W  broadcast RS tag.
- CDB_write  out  1  CDB valid strobe, one cycle.
- starve  out  NUM_UNITS  sticky per-unit starvation flag.

Behaviour:
- Reset values: unit_xmit=0, CDB_write=0, CDB_data=0, CDB_source=0, starve=0, rr pointer=0, wait counters=0. Reset mid-transfer drops any pending grant and bus beat; nothing is broadcast.
- Eligible set at each edge: unit_rts & ~unit_xmit. A unit granted in cycle k is masked at edge k+1, so a unit whose rts is still high during its xmit cycle is never double-granted.
- Grant at edge E: if ~cdb_hold and the eligible set is non-zero, set unit_xmit to the one-hot of the first eligible unit at or after ptr, searching circularly. Then ptr <= granted+1 mod NUM_UNITS. Otherwise unit_xmit <= 0 and ptr is unchanged.
- Transfer stage, one-state pipeline:
  - At the edge following a grant to unit g: CDB_data <= unit_data[g], CDB_source <= unit_source[g], CDB_write <= 1.
  - Otherwise CDB_write <= 0 and CDB_data/CDB_source hold their last values.
  - Total latency rts->CDB_write is 2 cycles when uncontended.
- Unit contract: data and source stay stable while xmit is high; rts is dropped on the edge that ends xmit. This is checked by an assertion, not corrected.
- Throughput: one broadcast per cycle when two or more units alternate. Back-to-back grants to different units are allowed.
- cdb_hold:
  - Suppresses only new grants.
  - A grant already issued still completes its CDB_write beat.
  - Hold asserted and released in the same request window keeps the rr order.
- Simultaneous requests: rotating priority from ptr. No unit waits more than NUM_UNITS grants while hold is low.
- Wait counters:
  - Per unit, saturating at MAX_WAIT.
  - Increment while rts is high and the unit is not granted. Clear on grant or when rts is low.
  - starve[i] sets when counter i reaches MAX_WAIT and stays set until reset.
- Single request with NUM_UNITS=1: grant on alternate cycles only, giving the rts&~xmit pattern.

Decomposition:
- Shared package cdb_pkg holds DATA_W, TAG_W defaults and the RS tag constants shared with the register file and the adder RS.
- One natural sub-module: rr_priority_pick. It is combinational: takes request vector and pointer, returns one-hot grant and index. The FSM, pipeline and counters stay in cdb_arbiter.

Test Plan:
- Single unit: reset, unit0 rts=1, data=32'h0000_0005, source=6'b000001 held -> xmit0 pulses every other cycle; CDB_write one cycle after each xmit with CDB_data=5, CDB_source=000001.
- Three units request together at ptr=0 -> xmit order 0,1,2 on consecutive cycles; CDB_write high for three consecutive cycles carrying each unit's data/tag in that order.
- cdb_hold=1 for 4 cycles with units 1,2 pending, released -> no xmit during hold; after release unit1 then unit2 are granted. A grant issued in the cycle hold rose still produces its CDB_write.
- Reset asserted in the cycle xmit2=1 -> next cycle CDB_write=0, all outputs 0, ptr=0; unit2 re-requesting is granted fresh.
- Starvation: MAX_WAIT=3, cdb_hold=1, unit0 rts held 3 cycles -> starve[0]=1 and stays 1 after grant, until reset.
- Fairness soak: all units rts continuously for 300 cycles -> each unit receives exactly 100 grants, no xmit overlap, and never the same unit on consecutive cycles.
